spi_byte_master: RTL

Single-byte, full-duplex SPI master engine (mode 0, MSB first) that serves the boot sequencer and any other housekeeping client. A client pulses `start_i` with a byte. The block shifts that byte out on MOSI while shifting one byte in from MISO, then pulses `done_o` with the received byte. Chip select is not generated here; the client owns the flash CSB line.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_clk_gen.sv | 52 +++++
 rtl/spi_byte_master.sv | 138 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte master and its clients.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } spi_state_t;

    localparam logic [7:0] SPI_FLASH_READ_CMD = 8'h03;
    localparam int         SPI_BYTE_BITS      = 8;

endpackage

// File: rtl/spi_clk_gen.sv
// SCK phase counter: counts CLK_DIV cycles per half-period and flags the
// last cycle of each LOW and HIGH phase so the FSM can act on the transition.
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    input  logic clear_i,
    output logic rise_stb_o,
    output logic fall_stb_o,
    output logic sck_o
);

    localparam int             CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] phase_q, phase_d;
    logic          level_q, level_d;
    logic          phaseEnd;

    assign phaseEnd   = run_i && (phase_q == LAST);
    assign rise_stb_o = phaseEnd && !level_q;
    assign fall_stb_o = phaseEnd && level_q;
    assign sck_o      = level_q;

    // The counter restarts on every phase change, so it never wraps mid-phase.
    always_comb begin
        phase_d = phase_q;
        level_d = level_q;
        if (clear_i) begin
            phase_d = '0;
            level_d = 1'b0;
        end else if (phaseEnd) begin
            phase_d = '0;
            level_d = ~level_q;
        end else if (run_i) begin
            phase_d = phase_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= '0;
            level_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/spi_byte_master.sv
// Single-byte full-duplex SPI master, mode 0, MSB first.
// Optional SPI_MISO_SYNC_EN: synchronize MISO and sample at the end of HIGH.
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       done_o,
    output logic       busy_o,
    output logic       sck_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : gBadDiv
        $error("spi_byte_master: CLK_DIV must be in 1..255");
    end

    spi_state_t  state_q, state_d;
    logic [7:0]  txShift_q, txShift_d;
    logic [7:0]  rxShift_q, rxShift_d;
    logic [7:0]  rxByte_q, rxByte_d;
    logic [2:0]  bitCount_q, bitCount_d;
    logic [7:0]  rxNow;
    logic        riseStb, fallStb, sckLevel;
    logic        sampleNow, sampleBit;
    logic        inTransfer;

    assign inTransfer = (state_q == LOW) || (state_q == HIGH);

    spi_clk_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_clk_gen (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .run_i      (inTransfer),
        .clear_i    (!inTransfer),
        .rise_stb_o (riseStb),
        .fall_stb_o (fallStb),
        .sck_o      (sckLevel)
    );

`ifdef SPI_MISO_SYNC_EN
    if (CLK_DIV < 3) begin : gBadSyncDiv
        $error("spi_byte_master: SPI_MISO_SYNC_EN needs CLK_DIV >= 3");
    end

    logic [1:0] misoSync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            misoSync_q <= 2'b00;
        end else begin
            misoSync_q <= {misoSync_q[0], miso_i};
        end
    end

    assign sampleBit = misoSync_q[1];
    assign sampleNow = fallStb;
`else
    assign sampleBit = miso_i;
    assign sampleNow = riseStb;
`endif

    // Includes the bit captured this cycle so the final sample reaches data_o.
    assign rxNow = sampleNow ? {rxShift_q[6:0], sampleBit} : rxShift_q;

    always_comb begin
        state_d    = state_q;
        txShift_d  = txShift_q;
        rxShift_d  = rxShift_q;
        rxByte_d   = rxByte_q;
        bitCount_d = bitCount_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = LOW;
                    txShift_d  = data_i;
                    rxShift_d  = 8'h00;
                    bitCount_d = 3'd0;
                end
            end
            LOW: begin
                rxShift_d = rxNow;
                if (riseStb) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                rxShift_d = rxNow;
                if (fallStb) begin
                    txShift_d  = {txShift_q[6:0], 1'b0};
                    bitCount_d = bitCount_q + 3'd1;
                    if (bitCount_q == 3'(SPI_BYTE_BITS - 1)) begin
                        state_d  = DONE;
                        rxByte_d = rxNow;
                    end else begin
                        state_d = LOW;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            txShift_q  <= 8'h00;
            rxShift_q  <= 8'h00;
            rxByte_q   <= 8'h00;
            bitCount_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            txShift_q  <= txShift_d;
            rxShift_q  <= rxShift_d;
            rxByte_q   <= rxByte_d;
            bitCount_q <= bitCount_d;
        end
    end

    assign busy_o = inTransfer;
    assign done_o = (state_q == DONE);
    assign mosi_o = inTransfer && txShift_q[7];
    assign sck_o  = sckLevel;
    assign data_o = rxByte_q;

endmodule
